// File: rtl/riscv_pkg.sv
// RV32I shared encodings: opcodes, ALU operations, instruction categories,
// immediate formats and the decode-stage select / state enums.
// Optional RV32M decode is enabled in id_stage_pipe by defining ID_MULDIV_EN.
package riscv_pkg;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;

    localparam logic [4:0] AluAdd    = 5'd0;
    localparam logic [4:0] AluSub    = 5'd1;
    localparam logic [4:0] AluSll    = 5'd2;
    localparam logic [4:0] AluSlt    = 5'd3;
    localparam logic [4:0] AluSltu   = 5'd4;
    localparam logic [4:0] AluXor    = 5'd5;
    localparam logic [4:0] AluSrl    = 5'd6;
    localparam logic [4:0] AluSra    = 5'd7;
    localparam logic [4:0] AluOr     = 5'd8;
    localparam logic [4:0] AluAnd    = 5'd9;
    // MUL..REMU occupy 10..17 in funct3 order
    localparam logic [4:0] AluMul    = 5'd10;
    localparam logic [4:0] AluBeq    = 5'd18;
    localparam logic [4:0] AluBne    = 5'd19;
    localparam logic [4:0] AluBlt    = 5'd20;
    localparam logic [4:0] AluBge    = 5'd21;
    localparam logic [4:0] AluBltu   = 5'd22;
    localparam logic [4:0] AluBgeu   = 5'd23;

    localparam logic [2:0] CatOp     = 3'd0;
    localparam logic [2:0] CatOpi    = 3'd1;
    localparam logic [2:0] CatLoad   = 3'd2;
    localparam logic [2:0] CatStore  = 3'd3;
    localparam logic [2:0] CatBranch = 3'd4;
    localparam logic [2:0] CatJal    = 3'd5;
    localparam logic [2:0] CatJalr   = 3'd6;
    localparam logic [2:0] CatUpper  = 3'd7;  // LUI and AUIPC

    typedef enum logic [2:0] {FmtNone, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtShamt} imm_fmt_e;
    typedef enum logic [1:0] {Op1Rs1, Op1Pc, Op1Zero} op1_sel_e;
    typedef enum logic [1:0] {Op2Rs2, Op2Imm, Op2Four} op2_sel_e;
    typedef enum logic {StEmpty, StFull} id_state_e;

    function automatic logic [4:0] muldiv_op(input logic [2:0] funct3);
        return AluMul + {2'b00, funct3};
    endfunction

endpackage

// File: rtl/id_imm_gen.sv
// Combinational immediate generator: produces all five sign-extended RV32I
// immediates (I, S, B, U, J) from the instruction word.
// Ports: inst_i (inst[31:7]), imm_i_o, imm_s_o, imm_b_o, imm_u_o, imm_j_o.
module id_imm_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     inst_i,
    output logic [XLEN-1:0] imm_i_o,
    output logic [XLEN-1:0] imm_s_o,
    output logic [XLEN-1:0] imm_b_o,
    output logic [XLEN-1:0] imm_u_o,
    output logic [XLEN-1:0] imm_j_o
);

    assign imm_i_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_s_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b_o = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                      inst_i[11:8], 1'b0};
    assign imm_u_o = {{(XLEN-31){inst_i[31]}}, inst_i[30:12], 12'b0};
    assign imm_j_o = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                      inst_i[30:21], 1'b0};

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage. Accepts PC/instruction from IF over valid/ready, reads
// the external register file, forwards from EX/MEM, stalls on load-use and
// drives a registered ID/EX bundle.
// Ports: clk/rst (sync, active-low); if_valid_i/if_ready_o, pc_i, inst_i;
// rf_raddr*_o / rf_rdata*_i; ex_fwd_* and mem_fwd_* forwarding; flush_i;
// ex_ready_i / ex_valid_o and the ex_* bundle.
// Build option: ID_MULDIV_EN decodes the RV32M group, otherwise it is illegal.
module id_stage_pipe
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 5,
    parameter int unsigned CAT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid_i,
    output logic               if_ready_o,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [31:0]        inst_i,
    output logic [REG_AW-1:0]  rf_raddr1_o,
    input  logic [XLEN-1:0]    rf_rdata1_i,
    output logic [REG_AW-1:0]  rf_raddr2_o,
    input  logic [XLEN-1:0]    rf_rdata2_i,
    input  logic               ex_fwd_wen_i,
    input  logic [REG_AW-1:0]  ex_fwd_rd_i,
    input  logic [XLEN-1:0]    ex_fwd_dat_i,
    input  logic               ex_fwd_ld_i,
    input  logic               mem_fwd_wen_i,
    input  logic [REG_AW-1:0]  mem_fwd_rd_i,
    input  logic [XLEN-1:0]    mem_fwd_dat_i,
    input  logic               flush_i,
    input  logic               ex_ready_i,
    output logic               ex_valid_o,
    output logic [XLEN-1:0]    ex_pc_o,
    output logic [XLEN-1:0]    ex_imm_o,
    output logic [XLEN-1:0]    ex_op1_o,
    output logic [XLEN-1:0]    ex_op2_o,
    output logic [XLEN-1:0]    ex_rs1_o,
    output logic [XLEN-1:0]    ex_rs2_o,
    output logic [ALUOP_W-1:0] ex_aluop_o,
    output logic [CAT_W-1:0]   ex_cat_o,
    output logic [REG_AW-1:0]  ex_rd_o,
    output logic               ex_wen_o,
    output logic               ex_illegal_o
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rs1, rs2, rd;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign funct7 = inst_i[31:25];

    assign rf_raddr1_o = rs1;
    assign rf_raddr2_o = rs2;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst_i  (inst_i[31:7]),
        .imm_i_o (imm_i),
        .imm_s_o (imm_s),
        .imm_b_o (imm_b),
        .imm_u_o (imm_u),
        .imm_j_o (imm_j)
    );

    // Decode
    logic [ALUOP_W-1:0] aluop;
    logic [CAT_W-1:0]   cat;
    logic               illegal, writes_rd, use1, use2;
    imm_fmt_e           fmt;
    op1_sel_e           op1_sel;
    op2_sel_e           op2_sel;

    always_comb begin
        aluop     = AluAdd;
        cat       = CatOp;
        illegal   = 1'b0;
        writes_rd = 1'b0;
        use1      = 1'b0;
        use2      = 1'b0;
        fmt       = FmtNone;
        op1_sel   = Op1Rs1;
        op2_sel   = Op2Rs2;
        case (opcode)
            OpcLui: begin
                cat = CatUpper; fmt = FmtU; writes_rd = 1'b1;
                op1_sel = Op1Zero; op2_sel = Op2Imm;
            end
            OpcAuipc: begin
                cat = CatUpper; fmt = FmtU; writes_rd = 1'b1;
                op1_sel = Op1Pc; op2_sel = Op2Imm;
            end
            OpcJal: begin
                cat = CatJal; fmt = FmtJ; writes_rd = 1'b1;
                op1_sel = Op1Pc; op2_sel = Op2Four;
            end
            OpcJalr: begin
                cat = CatJalr; fmt = FmtI; writes_rd = 1'b1; use1 = 1'b1;
                op1_sel = Op1Pc; op2_sel = Op2Four;
                illegal = (funct3 != 3'b000);
            end
            OpcBranch: begin
                cat = CatBranch; fmt = FmtB; use1 = 1'b1; use2 = 1'b1;
                case (funct3)
                    3'b000:  aluop = AluBeq;
                    3'b001:  aluop = AluBne;
                    3'b100:  aluop = AluBlt;
                    3'b101:  aluop = AluBge;
                    3'b110:  aluop = AluBltu;
                    3'b111:  aluop = AluBgeu;
                    default: illegal = 1'b1;
                endcase
            end
            OpcLoad: begin
                cat = CatLoad; fmt = FmtI; writes_rd = 1'b1; use1 = 1'b1; op2_sel = Op2Imm;
                illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OpcStore: begin
                cat = CatStore; fmt = FmtS; use1 = 1'b1; use2 = 1'b1; op2_sel = Op2Imm;
                illegal = (funct3[2] || funct3 == 3'b011);
            end
            OpcOpImm: begin
                cat = CatOpi; fmt = FmtI; writes_rd = 1'b1; use1 = 1'b1; op2_sel = Op2Imm;
                case (funct3)
                    3'b000: aluop = AluAdd;
                    3'b010: aluop = AluSlt;
                    3'b011: aluop = AluSltu;
                    3'b100: aluop = AluXor;
                    3'b110: aluop = AluOr;
                    3'b111: aluop = AluAnd;
                    3'b001: begin
                        fmt = FmtShamt; aluop = AluSll;
                        illegal = (funct7 != 7'b0000000);
                    end
                    default: begin
                        fmt = FmtShamt;
                        aluop = inst_i[30] ? AluSra : AluSrl;
                        illegal = ({funct7[6], funct7[4:0]} != 6'b0);
                    end
                endcase
            end
            OpcOp: begin
                cat = CatOp; writes_rd = 1'b1; use1 = 1'b1; use2 = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  aluop = AluAdd;
                            3'b001:  aluop = AluSll;
                            3'b010:  aluop = AluSlt;
                            3'b011:  aluop = AluSltu;
                            3'b100:  aluop = AluXor;
                            3'b101:  aluop = AluSrl;
                            3'b110:  aluop = AluOr;
                            default: aluop = AluAnd;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      aluop = AluSub;
                        else if (funct3 == 3'b101) aluop = AluSra;
                        else                       illegal = 1'b1;
                    end
`ifdef ID_MULDIV_EN
                    7'b0000001: aluop = muldiv_op(funct3);
`endif
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (inst_i[1:0] != 2'b11) illegal = 1'b1;
        if (illegal) begin
            aluop     = AluAdd;
            writes_rd = 1'b0;
            use1      = 1'b0;
            use2      = 1'b0;
        end
    end

    logic [XLEN-1:0] imm;
    always_comb begin
        case (fmt)
            FmtI:     imm = imm_i;
            FmtS:     imm = imm_s;
            FmtB:     imm = imm_b;
            FmtU:     imm = imm_u;
            FmtJ:     imm = imm_j;
            FmtShamt: imm = XLEN'(inst_i[24:20]);
            default:  imm = '0;
        endcase
    end

    // Operand resolution: x0, then EX (loads have no data yet), then MEM, then RF
    logic [XLEN-1:0] rs1_val, rs2_val;
    always_comb begin
        if (rs1 == '0)                                            rs1_val = '0;
        else if (ex_fwd_wen_i && !ex_fwd_ld_i && ex_fwd_rd_i == rs1) rs1_val = ex_fwd_dat_i;
        else if (mem_fwd_wen_i && mem_fwd_rd_i == rs1)            rs1_val = mem_fwd_dat_i;
        else                                                      rs1_val = rf_rdata1_i;
        if (rs2 == '0)                                            rs2_val = '0;
        else if (ex_fwd_wen_i && !ex_fwd_ld_i && ex_fwd_rd_i == rs2) rs2_val = ex_fwd_dat_i;
        else if (mem_fwd_wen_i && mem_fwd_rd_i == rs2)            rs2_val = mem_fwd_dat_i;
        else                                                      rs2_val = rf_rdata2_i;
    end

    logic load_use;
    assign load_use = ex_fwd_ld_i && ex_fwd_wen_i && (ex_fwd_rd_i != '0) &&
                      ((use1 && ex_fwd_rd_i == rs1) || (use2 && ex_fwd_rd_i == rs2));

    logic [XLEN-1:0] op1, op2;
    always_comb begin
        case (op1_sel)
            Op1Pc:   op1 = pc_i;
            Op1Zero: op1 = '0;
            default: op1 = rs1_val;
        endcase
        case (op2_sel)
            Op2Imm:  op2 = imm;
            Op2Four: op2 = XLEN'(4);
            default: op2 = rs2_val;
        endcase
    end

    // Output register FSM
    id_state_e state_q, state_d;
    logic      accept;

    assign if_ready_o = (state_q == StEmpty || ex_ready_i) && !load_use && !flush_i;
    assign accept     = if_valid_i && if_ready_o;
    assign ex_valid_o = (state_q == StFull);

    always_comb begin
        state_d = state_q;
        if (flush_i)                               state_d = StEmpty;
        else if (accept)                           state_d = StFull;
        else if (state_q == StFull && ex_ready_i)  state_d = StEmpty;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StEmpty;
            ex_pc_o      <= '0;
            ex_imm_o     <= '0;
            ex_op1_o     <= '0;
            ex_op2_o     <= '0;
            ex_rs1_o     <= '0;
            ex_rs2_o     <= '0;
            ex_aluop_o   <= '0;
            ex_cat_o     <= '0;
            ex_rd_o      <= '0;
            ex_wen_o     <= 1'b0;
            ex_illegal_o <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ex_pc_o      <= pc_i;
                ex_imm_o     <= imm;
                ex_op1_o     <= op1;
                ex_op2_o     <= op2;
                ex_rs1_o     <= rs1_val;
                ex_rs2_o     <= rs2_val;
                ex_aluop_o   <= aluop;
                ex_cat_o     <= cat;
                ex_rd_o      <= rd;
                ex_wen_o     <= writes_rd && (rd != '0);
                ex_illegal_o <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid_i, if_ready_o;
    logic [31:0] pc_i, inst_i;
    logic [4:0]  rf_raddr1_o, rf_raddr2_o;
    logic [31:0] rf_rdata1_i, rf_rdata2_i;
    logic        ex_fwd_wen_i, ex_fwd_ld_i, mem_fwd_wen_i;
    logic [4:0]  ex_fwd_rd_i, mem_fwd_rd_i;
    logic [31:0] ex_fwd_dat_i, mem_fwd_dat_i;
    logic        flush_i, ex_ready_i, ex_valid_o;
    logic [31:0] ex_pc_o, ex_imm_o, ex_op1_o, ex_op2_o, ex_rs1_o, ex_rs2_o;
    logic [4:0]  ex_aluop_o, ex_rd_o;
    logic [2:0]  ex_cat_o;
    logic        ex_wen_o, ex_illegal_o;

    always #5 clk = ~clk;

    // Register file model; x0 holds a nonzero value so the DUT must force it to 0
    logic [31:0] rf_mem [32];
    assign rf_rdata1_i = rf_mem[rf_raddr1_o];
    assign rf_rdata2_i = rf_mem[rf_raddr2_o];

    id_stage_pipe u_dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid_i    (if_valid_i),
        .if_ready_o    (if_ready_o),
        .pc_i          (pc_i),
        .inst_i        (inst_i),
        .rf_raddr1_o   (rf_raddr1_o),
        .rf_rdata1_i   (rf_rdata1_i),
        .rf_raddr2_o   (rf_raddr2_o),
        .rf_rdata2_i   (rf_rdata2_i),
        .ex_fwd_wen_i  (ex_fwd_wen_i),
        .ex_fwd_rd_i   (ex_fwd_rd_i),
        .ex_fwd_dat_i  (ex_fwd_dat_i),
        .ex_fwd_ld_i   (ex_fwd_ld_i),
        .mem_fwd_wen_i (mem_fwd_wen_i),
        .mem_fwd_rd_i  (mem_fwd_rd_i),
        .mem_fwd_dat_i (mem_fwd_dat_i),
        .flush_i       (flush_i),
        .ex_ready_i    (ex_ready_i),
        .ex_valid_o    (ex_valid_o),
        .ex_pc_o       (ex_pc_o),
        .ex_imm_o      (ex_imm_o),
        .ex_op1_o      (ex_op1_o),
        .ex_op2_o      (ex_op2_o),
        .ex_rs1_o      (ex_rs1_o),
        .ex_rs2_o      (ex_rs2_o),
        .ex_aluop_o    (ex_aluop_o),
        .ex_cat_o      (ex_cat_o),
        .ex_rd_o       (ex_rd_o),
        .ex_wen_o      (ex_wen_o),
        .ex_illegal_o  (ex_illegal_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc, imm, op1, op2, rs1, rs2;
        logic [4:0]  aluop, rd;
        logic [2:0]  cat;
        logic        wen, ill;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(input logic [31:0] pc, imm, op1, op2, rs1, rs2,
                                input logic [4:0] aluop, input logic [2:0] cat,
                                input logic [4:0] rd, input logic wen, ill);
        exp_t e;
        e.pc = pc; e.imm = imm; e.op1 = op1; e.op2 = op2; e.rs1 = rs1; e.rs2 = rs2;
        e.aluop = aluop; e.cat = cat; e.rd = rd; e.wen = wen; e.ill = ill;
        return e;
    endfunction

    function automatic logic [31:0] rfv(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : rf_mem[a];
    endfunction

    // Bundles are compared when EX takes them
    always @(negedge clk) begin
        if (rst && ex_valid_o && ex_ready_i) begin
            check_val("sb_occupied", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check_val("pc",    ex_pc_o,    e.pc);
                check_val("imm",   ex_imm_o,   e.imm);
                check_val("op1",   ex_op1_o,   e.op1);
                check_val("op2",   ex_op2_o,   e.op2);
                check_val("rs1",   ex_rs1_o,   e.rs1);
                check_val("rs2",   ex_rs2_o,   e.rs2);
                check_val("aluop", 32'(ex_aluop_o), 32'(e.aluop));
                check_val("cat",   32'(ex_cat_o),   32'(e.cat));
                check_val("rd",    32'(ex_rd_o),    32'(e.rd));
                check_val("wen",   32'(ex_wen_o),   32'(e.wen));
                check_val("illegal", 32'(ex_illegal_o), 32'(e.ill));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction, wait (bounded) for acceptance, record its expected bundle
    task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input exp_t e);
        bit done = 0;
        if_valid_i = 1'b1;
        pc_i       = pc;
        inst_i     = inst;
        #1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (if_ready_o) begin
                sb.push_back(e);
                done = 1;
            end
            step();
        end
        if (!done) check_val("issue_timeout", 32'(if_ready_o), 32'd1);
        if_valid_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 + i;
        rst = 1'b0; if_valid_i = 0; pc_i = 0; inst_i = 0;
        ex_fwd_wen_i = 0; ex_fwd_rd_i = 0; ex_fwd_dat_i = 0; ex_fwd_ld_i = 0;
        mem_fwd_wen_i = 0; mem_fwd_rd_i = 0; mem_fwd_dat_i = 0;
        flush_i = 0; ex_ready_i = 1;
        repeat (3) step();
        check_val("rst_valid", 32'(ex_valid_o), 32'd0);
        check_val("rst_pc", ex_pc_o, 32'd0);
        check_val("rst_op2", ex_op2_o, 32'd0);
        check_val("rst_wen", 32'(ex_wen_o), 32'd0);
        rst = 1'b1;
        step();
        check_val("rst_ready", 32'(if_ready_o), 32'd1);

        // ADDI x1,x0,5
        issue(32'h100, 32'h00500093,
              mk(32'h100, 5, 0, 5, 0, rfv(5), AluAdd, CatOpi, 1, 1, 0));

        // EX and MEM both hold x1: EX wins
        ex_fwd_wen_i = 1; ex_fwd_rd_i = 1; ex_fwd_dat_i = 32'h11;
        mem_fwd_wen_i = 1; mem_fwd_rd_i = 1; mem_fwd_dat_i = 32'h22;
        issue(32'h104, 32'h001081B3,
              mk(32'h104, 0, 32'h11, 32'h11, 32'h11, 32'h11, AluAdd, CatOp, 3, 1, 0));
        ex_fwd_wen_i = 0;
        issue(32'h108, 32'h001081B3,
              mk(32'h108, 0, 32'h22, 32'h22, 32'h22, 32'h22, AluAdd, CatOp, 3, 1, 0));
        // SUB x4,x2,x1
        issue(32'h10C, 32'h40110233,
              mk(32'h10C, 0, rfv(2), 32'h22, rfv(2), 32'h22, AluSub, CatOp, 4, 1, 0));
        mem_fwd_wen_i = 0;

        // Load-use: EX is LW x5, ID holds ADD x6,x5,x0
        ex_fwd_wen_i = 1; ex_fwd_ld_i = 1; ex_fwd_rd_i = 5; ex_fwd_dat_i = 32'hDEAD;
        if_valid_i = 1; pc_i = 32'h110; inst_i = 32'h00028333;
        #1;
        check_val("lu_ready", 32'(if_ready_o), 32'd0);
        step();
        check_val("lu_bubble", 32'(ex_valid_o), 32'd0);
        ex_fwd_wen_i = 0; ex_fwd_ld_i = 0;
        mem_fwd_wen_i = 1; mem_fwd_rd_i = 5; mem_fwd_dat_i = 32'h55;
        issue(32'h110, 32'h00028333,
              mk(32'h110, 0, 32'h55, 0, 32'h55, 0, AluAdd, CatOp, 6, 1, 0));
        mem_fwd_wen_i = 0;

        // BEQ x1,x2,+8 and JAL x1,+16
        issue(32'h200, 32'h00208463,
              mk(32'h200, 8, rfv(1), rfv(2), rfv(1), rfv(2), AluBeq, CatBranch, 8, 0, 0));
        issue(32'h300, 32'h010000EF,
              mk(32'h300, 16, 32'h300, 4, 0, rfv(16), AluAdd, CatJal, 1, 1, 0));

        // Backpressure: ADDI x7,x0,-1 held while EX is not ready
        issue(32'h400, 32'hFFF00393,
              mk(32'h400, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, rfv(31), AluAdd, CatOpi, 7, 1, 0));
        ex_ready_i = 0;
        if_valid_i = 1; pc_i = 32'h404; inst_i = 32'h12345437;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("bp_ready", 32'(if_ready_o), 32'd0);
            check_val("bp_valid", 32'(ex_valid_o), 32'd1);
            check_val("bp_pc", ex_pc_o, 32'h400);
            check_val("bp_op2", ex_op2_o, 32'hFFFFFFFF);
            step();
        end
        ex_ready_i = 1;
        // LUI x8,0x12345
        issue(32'h404, 32'h12345437,
              mk(32'h404, 32'h12345000, 0, 32'h12345000, rfv(8), rfv(3), AluAdd, CatUpper,
                 8, 1, 0));

        // AUIPC x9,1 then a flush that must drop the offered instruction
        issue(32'h500, 32'h00001497,
              mk(32'h500, 32'h1000, 32'h500, 32'h1000, 0, 0, AluAdd, CatUpper, 9, 1, 0));
        if_valid_i = 1; pc_i = 32'h504; inst_i = 32'h00500093; flush_i = 1;
        #1;
        check_val("flush_ready", 32'(if_ready_o), 32'd0);
        step();
        flush_i = 0; if_valid_i = 0;
        check_val("flush_valid", 32'(ex_valid_o), 32'd0);

        // SRAI x10,x1,3
        issue(32'h600, 32'h4030D513,
              mk(32'h600, 3, rfv(1), 3, rfv(1), rfv(3), AluSra, CatOpi, 10, 1, 0));

        // MUL x0,x1,x2
`ifdef ID_MULDIV_EN
        issue(32'h700, 32'h02208033,
              mk(32'h700, 0, rfv(1), rfv(2), rfv(1), rfv(2), AluMul, CatOp, 0, 0, 0));
`else
        issue(32'h700, 32'h02208033,
              mk(32'h700, 0, rfv(1), rfv(2), rfv(1), rfv(2), AluAdd, CatOp, 0, 0, 1));
`endif
        // FENCE: unknown opcode here
        issue(32'h704, 32'h0000000F,
              mk(32'h704, 0, 0, 0, 0, 0, AluAdd, CatOp, 0, 0, 1));

        // Reset while a stalled bundle is held
        issue(32'h800, 32'h00500093,
              mk(32'h800, 5, 0, 5, 0, rfv(5), AluAdd, CatOpi, 1, 1, 0));
        ex_ready_i = 0;
        rst = 0;
        step();
        check_val("mrst_valid", 32'(ex_valid_o), 32'd0);
        check_val("mrst_pc", ex_pc_o, 32'd0);
        check_val("mrst_op2", ex_op2_o, 32'd0);
        check_val("mrst_wen", 32'(ex_wen_o), 32'd0);
        void'(sb.pop_back());
        rst = 1; ex_ready_i = 1;
        step();
        check_val("mrst_ready", 32'(if_ready_o), 32'd1);

        repeat (2) step();
        check_val("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
